hist_scan_streamer: RTL and testbench

Drives the per-pixel histogram readout toward the peak detector. On `start`, it walks every pixel's histogram RAM bin by bin and streams `noc`/`addr` pairs for two passes: a coarse pass (`his_num`=0), then a fine pass (`his_num`=1). It pulses `scan_finish` after each pass, waits for the detector's `peak_done` acknowledge, and clears bins to zero during the fine pass so the next acquisition starts from an empty histogram.

---
 rtl/hist_scan_streamer_if.sv | 35 +++
 rtl/hist_scan_streamer.sv | 125 ++++++++++++
 tb/tb_hist_scan_streamer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/hist_scan_streamer_if.sv
// Histogram readout bus: RAM read/clear port, detector stream and scan control.
// master = streamer side, slave = RAM/detector side.
interface hist_scan_streamer_if #(
  parameter int unsigned NB       = 6,
  parameter int unsigned PEAK_MAX = 21,
  parameter int unsigned PIX_W    = 3
);
  logic                  start;
  logic                  ram_rd_en;
  logic [PIX_W+NB-1:0]   ram_rd_addr;
  logic [PEAK_MAX-1:0]   ram_rd_data;
  logic                  ram_clr_en;
  logic [PIX_W+NB-1:0]   ram_clr_addr;
  logic [PEAK_MAX-1:0]   noc;
  logic [NB-1:0]         addr;
  logic                  noc_valid;
  logic                  his_num;
  logic [PIX_W-1:0]      pixel_idx;
  logic                  scan_finish;
  logic                  peak_done;
  logic                  busy;
  logic                  all_done;

  modport master (
    input  start, ram_rd_data, peak_done,
    output ram_rd_en, ram_rd_addr, ram_clr_en, ram_clr_addr, noc, addr, noc_valid,
           his_num, pixel_idx, scan_finish, busy, all_done
  );

  modport slave (
    output start, ram_rd_data, peak_done,
    input  ram_rd_en, ram_rd_addr, ram_clr_en, ram_clr_addr, noc, addr, noc_valid,
           his_num, pixel_idx, scan_finish, busy, all_done
  );
endinterface

// File: rtl/hist_scan_streamer.sv
// Walks every pixel histogram twice (coarse, then fine), streaming bin counts to the
// peak detector and zeroing each bin as the fine pass reads it.
module hist_scan_streamer #(
  parameter int unsigned NB        = 6,
  parameter int unsigned PEAK_MAX  = 21,
  parameter int unsigned PIXEL_NUM = 8,
  parameter int unsigned PIX_W     = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  hist_scan_streamer_if.master  bus
);

  typedef enum logic [2:0] {
    StIdle, StRead, StDrain, StFinish, StWaitAck, StAdvance
  } state_e;

  localparam logic [NB-1:0]    BinLast = '1;
  localparam logic [PIX_W-1:0] PixLast = PIX_W'(PIXEL_NUM - 1);

  state_e              state;
  logic [NB-1:0]       bin;
  logic [PIX_W-1:0]    pixIdx;
  logic                hisNum;
  logic                rdEn;
  logic                nocValid;
  logic [NB-1:0]       beatBin;
  logic                clrEn;
  logic [PIX_W+NB-1:0] clrAddr;
  logic                scanFinish;
  logic                busyQ;
  logic                allDone;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      bin        <= '0;
      pixIdx     <= '0;
      hisNum     <= 1'b0;
      rdEn       <= 1'b0;
      nocValid   <= 1'b0;
      beatBin    <= '0;
      clrEn      <= 1'b0;
      clrAddr    <= '0;
      scanFinish <= 1'b0;
      busyQ      <= 1'b0;
      allDone    <= 1'b0;
    end else begin
      // Data beat trails its read strobe by one cycle, matching RAM latency.
      nocValid   <= rdEn;
      beatBin    <= bin;
      clrEn      <= rdEn & hisNum;
      clrAddr    <= {pixIdx, bin};
      scanFinish <= 1'b0;
      allDone    <= 1'b0;
      unique case (state)
        StIdle: begin
          // busyQ still set here means this is the all_done cycle: drop start.
          if (busyQ) begin
            busyQ <= 1'b0;
          end else if (start_i()) begin
            state  <= StRead;
            pixIdx <= '0;
            hisNum <= 1'b0;
            bin    <= '0;
            rdEn   <= 1'b1;
            busyQ  <= 1'b1;
          end
        end
        StRead: begin
          if (bin == BinLast) begin
            rdEn  <= 1'b0;
            state <= StDrain;
          end else begin
            bin <= bin + 1'b1;
          end
        end
        StDrain: begin
          scanFinish <= 1'b1;
          state      <= StFinish;
        end
        StFinish: state <= StWaitAck;
        StWaitAck: begin
          if (bus.peak_done) state <= StAdvance;
        end
        StAdvance: begin
          bin <= '0;
          if (!hisNum) begin
            hisNum <= 1'b1;
            rdEn   <= 1'b1;
            state  <= StRead;
          end else if (pixIdx < PixLast) begin
            pixIdx <= pixIdx + 1'b1;
            hisNum <= 1'b0;
            rdEn   <= 1'b1;
            state  <= StRead;
          end else begin
            allDone <= 1'b1;
            state   <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  function automatic logic start_i();
    return bus.start;
  endfunction

  assign bus.ram_rd_en    = rdEn;
  assign bus.ram_rd_addr  = {pixIdx, bin};
  // Suppress the write-zero in the reset cycle so an abort never clears an extra bin.
  assign bus.ram_clr_en   = clrEn & ~reset;
  assign bus.ram_clr_addr = clrAddr;
  assign bus.noc          = nocValid ? bus.ram_rd_data : '0;
  assign bus.addr         = beatBin;
  assign bus.noc_valid    = nocValid;
  assign bus.his_num      = hisNum;
  assign bus.pixel_idx    = pixIdx;
  assign bus.scan_finish  = scanFinish;
  assign bus.busy         = busyQ;
  assign bus.all_done     = allDone;

endmodule

// File: tb/tb_hist_scan_streamer.sv
// Directed bench for hist_scan_streamer with a behavioural histogram RAM.
module tb_hist_scan_streamer;
  localparam int NB        = 6;
  localparam int PEAK_MAX  = 21;
  localparam int PIXEL_NUM = 8;
  localparam int PIX_W     = 3;
  localparam int BINS      = 1 << NB;
  localparam int WORDS     = 1 << (PIX_W + NB);

  logic clk = 1'b0;
  logic reset;
  logic load;
  always #5 clk = ~clk;

  hist_scan_streamer_if #(.NB(NB), .PEAK_MAX(PEAK_MAX), .PIX_W(PIX_W)) bus ();

  hist_scan_streamer #(.NB(NB), .PEAK_MAX(PEAK_MAX), .PIXEL_NUM(PIXEL_NUM), .PIX_W(PIX_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [PEAK_MAX-1:0] pat(input int p, input int b);
    if (p == 5 && b == 7) return {PEAK_MAX{1'b1}};
    return PEAK_MAX'((p << 8) | b);
  endfunction

  logic [PEAK_MAX-1:0] mem [0:WORDS-1];
  always @(posedge clk) begin
    if (load) begin
      for (int a = 0; a < WORDS; a++) mem[a] <= pat(a / BINS, a % BINS);
    end
    if (bus.ram_rd_en) bus.ram_rd_data <= mem[bus.ram_rd_addr];
    if (bus.ram_clr_en) mem[bus.ram_clr_addr] <= '0;
  end

  int sfCount = 0;
  int adCount = 0;
  always @(posedge clk) begin
    if (bus.scan_finish) sfCount <= sfCount + 1;
    if (bus.all_done) adCount <= adCount + 1;
  end

  int errors = 0;
  int checks = 0;
  logic                prevRdEn;
  logic [PIX_W+NB-1:0] prevRdAddr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    prevRdEn   = bus.ram_rd_en;
    prevRdAddr = bus.ram_rd_addr;
    @(posedge clk);
    #1;
  endtask

  // One pass: 64 beats, scan_finish, optional ack stall, then ack.
  task automatic run_pass(input int pix, input int his, input int ackDelay, input bit stray,
                          input bit zero);
    int n = 0;
    while (!bus.noc_valid && n < 6) begin
      tick();
      n++;
    end
    chk("first_beat_seen", 32'(bus.noc_valid), 1);
    for (int i = 0; i < BINS; i++) begin
      chk("beat_valid", 32'(bus.noc_valid), 1);
      chk("beat_addr", 32'(bus.addr), i);
      chk("beat_noc", 32'(bus.noc), zero ? 0 : 32'(pat(pix, i)));
      chk("beat_after_rd", {22'd0, prevRdEn, prevRdAddr}, (1 << (PIX_W + NB)) | (pix * BINS) | i);
      chk("beat_pix_his", {28'd0, bus.pixel_idx, bus.his_num}, pix * 2 + his);
      chk("beat_clr_en", 32'(bus.ram_clr_en), his);
      if (his != 0) chk("beat_clr_addr", 32'(bus.ram_clr_addr), pix * BINS + i);
      if (stray && i == 10) bus.peak_done = 1'b1;
      if (stray && i == 20) bus.start = 1'b1;
      tick();
      bus.peak_done = 1'b0;
      bus.start     = 1'b0;
    end
    chk("scan_finish", 32'(bus.scan_finish), 1);
    chk("finish_no_beat", 32'(bus.noc_valid), 0);
    tick();
    for (int k = 0; k < ackDelay; k++) begin
      chk("stall_quiet", {29'd0, bus.ram_rd_en, bus.noc_valid, bus.scan_finish}, 0);
      chk("stall_hold", {28'd0, bus.pixel_idx, bus.his_num}, pix * 2 + his);
      if (stray && k == 50) bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
    end
    bus.peak_done = 1'b1;
    tick();
    bus.peak_done = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk(tag, {25'd0, bus.busy, bus.all_done, bus.scan_finish, bus.noc_valid, bus.ram_rd_en,
              bus.ram_clr_en, bus.his_num}, 0);
    chk({tag, "_idx"}, {23'd0, bus.pixel_idx, bus.addr}, 0);
    chk({tag, "_rdaddr"}, 32'(bus.ram_rd_addr), 0);
    chk({tag, "_noc"}, 32'(bus.noc), 0);
  endtask

  initial begin
    int sf0;
    int ad0;
    int bad;
    int n;
    reset         = 1'b1;
    load          = 1'b0;
    bus.start     = 1'b0;
    bus.peak_done = 1'b0;
    tick();
    tick();
    chk_idle_outputs("reset_state");
    // start coincident with reset must be lost
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    reset     = 1'b0;
    chk("start_under_reset", 32'(bus.busy), 0);
    tick();
    chk("still_idle", {30'd0, bus.busy, bus.ram_rd_en}, 0);

    load = 1'b1;
    tick();
    load = 1'b0;

    // Full scan: stall 3 then immediate acks, one long stall with stray pulses.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_busy", 32'(bus.busy), 1);
    chk("start_rd", {22'd0, bus.ram_rd_en, bus.ram_rd_addr}, 1 << (PIX_W + NB));
    sf0 = sfCount;
    ad0 = adCount;
    run_pass(0, 0, 3, 1'b0, 1'b0);
    run_pass(0, 1, 0, 1'b0, 1'b0);
    bad = 0;
    for (int b = 0; b < BINS; b++) if (mem[b] !== '0) bad++;
    chk("pix0_cleared", bad, 0);
    run_pass(1, 0, 100, 1'b1, 1'b0);
    run_pass(1, 1, 0, 1'b0, 1'b0);
    for (int p = 2; p < PIXEL_NUM; p++) begin
      run_pass(p, 0, 0, 1'b0, 1'b0);
      run_pass(p, 1, 0, 1'b0, 1'b0);
    end
    tick();
    chk("all_done_pulse", {30'd0, bus.all_done, bus.busy}, 3);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("after_all_done", {30'd0, bus.all_done, bus.busy}, 0);
    tick();
    chk("start_in_done_ignored", {30'd0, bus.busy, bus.ram_rd_en}, 0);
    chk("finish_count", sfCount - sf0, 16);
    chk("all_done_count", adCount - ad0, 1);

    // Abort during pixel 3 fine pass when bin 20 is about to be cleared.
    load = 1'b1;
    tick();
    load = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int p = 0; p < 3; p++) begin
      run_pass(p, 0, 0, 1'b0, 1'b0);
      run_pass(p, 1, 0, 1'b0, 1'b0);
    end
    run_pass(3, 0, 0, 1'b0, 1'b0);
    n = 0;
    while (!(bus.ram_clr_en && bus.ram_clr_addr == (PIX_W + NB)'(3 * BINS + 20)) && n < 200) begin
      tick();
      n++;
    end
    chk("reach_bin20", n < 200 ? 1 : 0, 1);
    reset = 1'b1;
    #1;
    chk("clr_gated_in_reset", 32'(bus.ram_clr_en), 0);
    tick();
    chk_idle_outputs("abort_state");
    reset = 1'b0;
    bad = 0;
    for (int b = 0; b < BINS; b++) begin
      if (b < 20 && mem[3 * BINS + b] !== '0) bad++;
      if (b >= 20 && mem[3 * BINS + b] !== pat(3, b)) bad++;
    end
    chk("pix3_partial_clear", bad, 0);
    tick();
    tick();
    chk("abort_idle", {30'd0, bus.busy, bus.ram_rd_en}, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("restart_rd", {22'd0, bus.ram_rd_en, bus.ram_rd_addr}, 1 << (PIX_W + NB));
    run_pass(0, 0, 0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
